// File: rtl/avg_uart_tx.sv
// Buffers averaged samples in a small FIFO and sends each one as two UART bytes.
// Optional even parity bit per byte when AVG_UART_PARITY_EN is defined.
module avg_uart_tx #(
    parameter int DATA_W       = 10,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_i,
    input  logic              strobe_i,
    output logic              tx_o,
    output logic              busy_o,
    output logic              fifo_full_o,
    output logic              overflow_o
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef AVG_UART_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
`endif

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;

    logic [2:0]        state;
    logic [15:0]       baud_cnt;
    logic [2:0]        bit_idx;
    logic              byte_sel;
    logic [DATA_W-1:0] hold;
    logic [7:0]        cur_byte;
    logic              baud_done;
    logic              tx_q;
    logic              overflow_q;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = (state == ST_IDLE) && !fifo_empty;
    assign push       = strobe_i && (!fifo_full || pop);

    // High byte carries a marker in bit 7 so the receiver can resynchronise.
    assign cur_byte  = byte_sel ? {1'b1, 5'b00000, hold[9:8]} : hold[7:0];
    assign baud_done = (baud_cnt == BAUD_LAST);

    assign tx_o        = tx_q;
    assign busy_o      = (state != ST_IDLE) || !fifo_empty;
    assign fifo_full_o = fifo_full;
    assign overflow_o  = overflow_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (strobe_i && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // tx_q is loaded with the bit of the state being entered, so the line is glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_sel <= 1'b0;
            hold     <= '0;
            tx_q     <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    tx_q     <= 1'b1;
                    if (pop) begin
                        hold     <= mem[rd_ptr[AW-1:0]];
                        byte_sel <= 1'b0;
                        state    <= ST_START;
                        tx_q     <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                        tx_q     <= cur_byte[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef AVG_UART_PARITY_EN
                            state <= ST_PARITY;
                            tx_q  <= ^cur_byte;
`else
                            state <= ST_STOP;
                            tx_q  <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_q    <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
`ifdef AVG_UART_PARITY_EN
                ST_PARITY: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        state    <= ST_STOP;
                        tx_q     <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (!byte_sel) begin
                            byte_sel <= 1'b1;
                            state    <= ST_START;
                            tx_q     <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            tx_q  <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avg_uart_tx.sv
// Self-checking bench for avg_uart_tx: a cycle-level timeline model predicts tx_o and flags.
// Honours AVG_UART_PARITY_EN when defined.
module tb_avg_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef AVG_UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FB    = 10 + P;
    localparam int FRAME = 2 * FB * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] data_i = '0;
    logic       strobe_i = 1'b0;
    logic       tx_o;
    logic       busy_o;
    logic       fifo_full_o;
    logic       overflow_o;

    int checks = 0;
    int errors = 0;

    avg_uart_tx #(
        .DATA_W(10),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .data_i(data_i),
        .strobe_i(strobe_i),
        .tx_o(tx_o),
        .busy_o(busy_o),
        .fifo_full_o(fifo_full_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of waiting samples plus the edge at which the last sample started.
    logic [9:0] mq[$];
    logic [9:0] m_cur = '0;
    logic       m_over = 1'b0;
    int         n = 0;
    int         last_pop = -100000;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_over   = 1'b0;
            last_pop = -100000;
        end else begin
            n++;
            if (mq.size() > 0 && n >= last_pop + FRAME + 1) begin
                m_cur    = mq.pop_front();
                last_pop = n;
            end
            if (strobe_i) begin
                if (mq.size() < DEPTH) mq.push_back(data_i);
                else m_over = 1'b1;
            end
        end
    end

    function automatic logic exp_tx();
        int k, b, pos;
        logic [7:0] byt;
        k = n - last_pop;
        if (k < 0 || k >= FRAME) return 1'b1;
        b   = k / (FB * CPB);
        pos = (k % (FB * CPB)) / CPB;
        byt = (b == 0) ? m_cur[7:0] : {1'b1, 5'b00000, m_cur[9:8]};
        if (pos == 0) return 1'b0;
        if (pos <= 8) return byt[pos-1];
        if (P == 1 && pos == 9) return ^byt;
        return 1'b1;
    endfunction

    function automatic logic exp_busy();
        return (n - last_pop < FRAME) || (mq.size() > 0);
    endfunction

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("tx", tx_o, exp_tx());
        checkOutput("busy", busy_o, exp_busy());
        checkOutput("full", fifo_full_o, mq.size() == DEPTH);
        checkOutput("overflow", overflow_o, m_over);
    endtask

    // Checks outputs after the previous edge, then drives the inputs for the next edge.
    task automatic applyStimulus(input logic s, input logic [9:0] d);
        @(negedge clk);
        checkAll();
        strobe_i = s;
        data_i   = d;
    endtask

    task automatic idleCycles(input int cnt);
        for (int i = 0; i < cnt; i++) applyStimulus(1'b0, 10'h000);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        strobe_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int busy_len;

        // Reset state
        strobe_i = 1'b1;
        data_i   = 10'h3FF;
        repeat (3) @(negedge clk);
        checkOutput("rst_tx", tx_o, 1'b1);
        checkOutput("rst_busy", busy_o, 1'b0);
        checkOutput("rst_full", fifo_full_o, 1'b0);
        checkOutput("rst_over", overflow_o, 1'b0);
        strobe_i = 1'b0;
        reset = 1'b0;
        idleCycles(3);

        // Single sample 0x2A5, measure busy duration
        applyStimulus(1'b1, 10'h2A5);
        applyStimulus(1'b0, 10'h000);
        checkOutput("first_fall_pending", tx_o, 1'b1);
        busy_len = -1;
        for (int i = 1; i < FRAME + 10; i++) begin
            applyStimulus(1'b0, 10'h000);
            if (busy_len < 0 && busy_o === 1'b0) busy_len = i;
        end
        checks++;
        assert (busy_len == FRAME + 1)
        else begin
            errors++;
            $error("[TB] FAIL busy_len observed=%0d expected=%0d", busy_len, FRAME + 1);
        end

        // Six back-to-back strobes: sixth dropped
        for (int v = 1; v <= 6; v++) applyStimulus(1'b1, 10'(v));
        applyStimulus(1'b0, 10'h000);
        checkOutput("ovf_set", overflow_o, 1'b1);
        checkOutput("full_after6", fifo_full_o, 1'b1);
        idleCycles(5 * (FRAME + 1) + 10);
        checkOutput("drained_busy", busy_o, 1'b0);

        // Push while full coinciding with the idle pop
        doReset();
        for (int v = 0; v < 5; v++) applyStimulus(1'b1, 10'h100 + 10'(v));
        idleCycles(FRAME - 3);
        applyStimulus(1'b1, 10'h1FF);
        applyStimulus(1'b0, 10'h000);
        checkOutput("coincide_over", overflow_o, 1'b0);
        checkOutput("coincide_full", fifo_full_o, 1'b1);
        idleCycles(5 * (FRAME + 1) + 10);

        // Reset in the data phase of byte1
        doReset();
        applyStimulus(1'b1, 10'h155);
        idleCycles(FB * CPB + CPB + 11);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_tx", tx_o, 1'b1);
        checkOutput("midrst_busy", busy_o, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 10'h3FF);
        idleCycles(FRAME + 10);

        // Randomised traffic
        doReset();
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom_range(0, 15) == 0), 10'($urandom));
        end
        idleCycles(5 * (FRAME + 1) + 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
